// File: rtl/prio_encoder8.sv
// prio_encoder8: sequential 8-to-3 priority encoder.
// Request pulses accumulate in a pending register. The highest-numbered
// pending line is presented as an index under a valid/ack handshake, and
// that line is cleared when the index is acknowledged.
module prio_encoder8 #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         ack,
  output logic [W-1:0] idx,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [W-1:0] idx_next;
  logic [W-1:0] top_idx;
  logic [N-1:0] clr;
  logic [N-1:0] pending_next;
  logic         overflow_hit;

  // A grant is visible exactly while the FSM sits in GRANT.
  assign valid = (state == GRANT);

  // One-hot clear of the acknowledged line; zero when no handshake completes.
  always_comb begin
    clr = '0;
    if (valid && ack) begin
      clr[idx] = 1'b1;
    end
  end

  // Highest set bit of the registered pending vector; later bits override earlier ones.
  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending[i]) begin
        top_idx = W'(i);
      end
    end
  end

  // Set wins over clear on the same line, so a re-request during ack keeps the line pending.
  always_comb begin
    pending_next = (pending & ~clr) | req;
    overflow_hit = |(req & pending & ~clr);
  end

  // Next-state and next-index logic; a grant is held until acknowledged.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        idx_next = '0;
        if (en && (pending != '0)) begin
          idx_next   = top_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          idx_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        idx_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Pending accumulation and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_next;
      if (overflow_hit) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder8.sv
// tb_prio_encoder8: directed-vector bench for prio_encoder8.
module tb_prio_encoder8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       en;
  logic       ack;
  logic [2:0] idx;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  prio_encoder8 #(.N(8), .W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .en       (en),
    .ack      (ack),
    .idx      (idx),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; en = 1'b0; ack = 1'b0;
    #12;
    n_checks++;
    if ({idx, valid, pending, overflow} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got idx=%0d valid=%b pending=%h ovf=%b, want all 0", idx, valid, pending, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: got valid=%b pending=%h, want 0/00", valid, pending);
    end
  endtask

  task automatic test_single_request();
    en = 1'b1; ack = 1'b0; req = 8'h10;
    tick();
    req = '0;
    n_checks++;
    if (pending !== 8'h10 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge1: got pending=%h valid=%b, want 10/0", pending, valid);
    end
    tick();
    n_checks++;
    if (valid !== 1'b1 || idx !== 3'd4) begin
      n_fail++;
      $display("FAIL single_edge2: got valid=%b idx=%0d, want 1/4", valid, idx);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (valid !== 1'b1 || idx !== 3'd4 || pending !== 8'h10) begin
        n_fail++;
        $display("FAIL single_hold%0d: got valid=%b idx=%0d pending=%h, want 1/4/10", i, valid, idx, pending);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || idx !== 3'd0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL single_ack: got valid=%b idx=%0d pending=%h, want 0/0/00", valid, idx, pending);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ovf: got overflow=%b, want 0", overflow);
    end
  endtask

  task automatic test_priority_drain();
    logic [2:0] exp_idx [8];
    logic       exp_vld [8];
    exp_idx = '{3'd7, 3'd0, 3'd5, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
    exp_vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    en = 1'b1; ack = 1'b1; req = 8'b1010_0101;
    tick();
    req = '0;
    n_checks++;
    if (pending !== 8'hA5 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_load: got pending=%h valid=%b, want a5/0", pending, valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (valid !== exp_vld[i] || idx !== exp_idx[i]) begin
        n_fail++;
        $display("FAIL drain_step%0d: got valid=%b idx=%0d, want %b/%0d", i, valid, idx, exp_vld[i], exp_idx[i]);
      end
    end
    n_checks++;
    if (pending !== 8'h00) begin
      n_fail++;
      $display("FAIL drain_empty: got pending=%h, want 00", pending);
    end
    ack = 1'b0;
  endtask

  task automatic test_enable_gating();
    en = 1'b0; ack = 1'b0; req = 8'h02;
    tick();
    req = '0;
    ack = 1'b1;  // ack while idle must not touch pending
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (valid !== 1'b0 || pending !== 8'h02) begin
        n_fail++;
        $display("FAIL gate_hold%0d: got valid=%b pending=%h, want 0/02", i, valid, pending);
      end
    end
    ack = 1'b0;
    en = 1'b1;
    tick();
    n_checks++;
    if (valid !== 1'b1 || idx !== 3'd1) begin
      n_fail++;
      $display("FAIL gate_grant: got valid=%b idx=%0d, want 1/1", valid, idx);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (valid !== 1'b1 || idx !== 3'd1) begin
        n_fail++;
        $display("FAIL gate_stable%0d: got valid=%b idx=%0d, want 1/1", i, valid, idx);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL gate_ack: got valid=%b pending=%h, want 0/00", valid, pending);
    end
  endtask

  task automatic test_collision_overflow();
    en = 1'b1; ack = 1'b0; req = 8'h08;
    tick();
    req = '0;
    tick();
    n_checks++;
    if (valid !== 1'b1 || idx !== 3'd3) begin
      n_fail++;
      $display("FAIL coll_grant: got valid=%b idx=%0d, want 1/3", valid, idx);
    end
    ack = 1'b1; req = 8'h08;
    tick();
    ack = 1'b0; req = '0;
    n_checks++;
    if (valid !== 1'b0 || pending[3] !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_setwins: got valid=%b pending=%h ovf=%b, want 0/bit3 set/0", valid, pending, overflow);
    end
    tick();
    n_checks++;
    if (valid !== 1'b1 || idx !== 3'd3) begin
      n_fail++;
      $display("FAIL coll_regrant: got valid=%b idx=%0d, want 1/3", valid, idx);
    end
    req = 8'h08;
    tick();
    req = '0;
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got overflow=%b, want 1", overflow);
    end
    tick();
    n_checks++;
    if (overflow !== 1'b1 || valid !== 1'b1 || idx !== 3'd3) begin
      n_fail++;
      $display("FAIL ovf_hold: got ovf=%b valid=%b idx=%0d, want 1/1/3", overflow, valid, idx);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL ovf_sticky: got ovf=%b pending=%h, want 1/00", overflow, pending);
    end
  endtask

  task automatic test_reset_mid_grant();
    en = 1'b1; ack = 1'b0; req = 8'h41;
    tick();
    req = '0;
    tick();
    n_checks++;
    if (valid !== 1'b1 || idx !== 3'd6 || pending !== 8'h41) begin
      n_fail++;
      $display("FAIL mid_setup: got valid=%b idx=%0d pending=%h, want 1/6/41", valid, idx, pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({idx, valid, pending, overflow} !== 13'd0) begin
      n_fail++;
      $display("FAIL mid_async: got idx=%0d valid=%b pending=%h ovf=%b, want all 0", idx, valid, pending, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (valid !== 1'b0 || pending !== 8'h00) begin
        n_fail++;
        $display("FAIL mid_release%0d: got valid=%b pending=%h, want 0/00", i, valid, pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_priority_drain();
    test_enable_gating();
    test_collision_overflow();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
